// File: rtl/sdr_init_pkg.sv
// rtl/sdr_init_pkg.sv - shared states, command codes and sizing helper for the SDRAM init sequencer
package sdr_init_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWRUP,
    PRE,
    TRP_W,
    AREF,
    TRFC_W,
    MRS,
    TMRD_W,
    EMRS,
    DONE
  } init_state_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;

  function automatic int dly_cnt_width(input int pwrup, input int trp,
                                       input int trfc, input int tmrd);
    int m;
    m = pwrup;
    if (trp > m) m = trp;
    if (trfc > m) m = trfc;
    if (tmrd > m) m = tmrd;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sdr_init_seq_if.sv
// rtl/sdr_init_seq_if.sv - SDRAM command/address pin bundle driven by the init sequencer
interface sdr_init_seq_if #(
  parameter int SDR_AW = 12
);
  logic              sdr_cke;
  logic              sdr_cs_n;
  logic              sdr_ras_n;
  logic              sdr_cas_n;
  logic              sdr_we_n;
  logic [1:0]        sdr_ba;
  logic [SDR_AW-1:0] sdr_addr;

  modport master (
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
  );

  modport slave (
    input sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
  );
endinterface

// File: rtl/sdr_delay_cnt.sv
// rtl/sdr_delay_cnt.sv - loadable down-counter with zero flag, saturating at zero
module sdr_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdr_init_seq.sv
// rtl/sdr_init_seq.sv - JEDEC SDRAM power-up sequencer (NOP hold, PRE-ALL, AREFs, MRS)
// Optional extended mode register load after MRS: define SDR_INIT_EMRS_EN.
module sdr_init_seq
  import sdr_init_pkg::*;
#(
  parameter int PWRUP_CYCLES = 600,
  parameter int TRP          = 3,
  parameter int TRFC         = 7,
  parameter int TMRD         = 2,
  parameter int NUM_AREF     = 2,
  parameter int SDR_AW       = 12
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic              cfg_sdr_en,
  input  logic [SDR_AW-1:0] cfg_mode_reg,
`ifdef SDR_INIT_EMRS_EN
  input  logic [SDR_AW-1:0] cfg_ext_mode_reg,
`endif
  sdr_init_seq_if.master    pins,
  output logic              init_busy,
  output logic              init_done
);

  localparam int CW = dly_cnt_width(PWRUP_CYCLES, TRP, TRFC, TMRD);
  localparam int AW = $clog2(NUM_AREF + 1);

  localparam logic [CW-1:0] PWRUP_LD  = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] TRP_LD    = CW'(TRP - 1);
  localparam logic [CW-1:0] TRFC_LD   = CW'(TRFC - 1);
  localparam logic [CW-1:0] TMRD_LD   = CW'(TMRD - 1);
  localparam logic [AW-1:0] AREF_LAST = AW'(NUM_AREF);

  init_state_t       state_q, state_d;
  logic [AW-1:0]     aref_cnt_q, aref_cnt_d;
  logic              dly_load;
  logic [CW-1:0]     dly_ld_val;
  logic              dly_zero;
  init_state_t       after_mrs;

  logic              cke_q, cke_d;
  logic              cs_n_q, cs_n_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [1:0]        ba_q, ba_d;
  logic [SDR_AW-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef SDR_INIT_EMRS_EN
  logic ext_done_q, ext_done_d;
  assign after_mrs = ext_done_q ? DONE : EMRS;
`else
  assign after_mrs = DONE;
`endif

  sdr_delay_cnt #(.W(CW)) u_dly (
    .clk        (sdram_clk),
    .rst_n      (sdram_resetn),
    .load_i     (dly_load),
    .load_val_i (dly_ld_val),
    .zero_o     (dly_zero)
  );

  // The delay counter is loaded on entry to each command state, so the command
  // state itself counts as the first cycle of its spacing; delay 1 skips the wait.
  always_comb begin
    state_d    = state_q;
    aref_cnt_d = aref_cnt_q;
    dly_load   = 1'b0;
    dly_ld_val = '0;
`ifdef SDR_INIT_EMRS_EN
    ext_done_d = ext_done_q;
`endif

    case (state_q)
      IDLE:          if (cfg_sdr_en) state_d = PWRUP;
      PWRUP:         if (dly_zero) state_d = PRE;
      PRE, TRP_W:    state_d = dly_zero ? AREF : TRP_W;
      AREF, TRFC_W: begin
        if (!dly_zero)                    state_d = TRFC_W;
        else if (aref_cnt_q < AREF_LAST)  state_d = AREF;
        else                              state_d = MRS;
      end
      MRS, TMRD_W:   state_d = dly_zero ? after_mrs : TMRD_W;
`ifdef SDR_INIT_EMRS_EN
      EMRS:          state_d = dly_zero ? DONE : TMRD_W;
`endif
      DONE:          state_d = DONE;
      default:       state_d = IDLE;
    endcase

    cke_d  = (state_d != IDLE);
    cs_n_d = (state_d == IDLE);
    cmd_d  = CMD_NOP;
    ba_d   = 2'b00;
    addr_d = '0;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);

    case (state_d)
      PWRUP: begin
        if (state_q == IDLE) begin
          dly_load   = 1'b1;
          dly_ld_val = PWRUP_LD;
        end
      end
      PRE: begin
        dly_load   = 1'b1;
        dly_ld_val = TRP_LD;
        cmd_d      = CMD_PRE;
        addr_d[10] = 1'b1;
      end
      AREF: begin
        dly_load   = 1'b1;
        dly_ld_val = TRFC_LD;
        cmd_d      = CMD_AREF;
        if (aref_cnt_q != AREF_LAST) aref_cnt_d = aref_cnt_q + 1'b1;
      end
      MRS: begin
        dly_load   = 1'b1;
        dly_ld_val = TMRD_LD;
        cmd_d      = CMD_MRS;
        addr_d     = cfg_mode_reg;
      end
`ifdef SDR_INIT_EMRS_EN
      EMRS: begin
        dly_load   = 1'b1;
        dly_ld_val = TMRD_LD;
        cmd_d      = CMD_MRS;
        ba_d       = 2'b01;
        addr_d     = cfg_ext_mode_reg;
        ext_done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q    <= IDLE;
      aref_cnt_q <= '0;
`ifdef SDR_INIT_EMRS_EN
      ext_done_q <= 1'b0;
`endif
      cke_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'b00;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aref_cnt_q <= aref_cnt_d;
`ifdef SDR_INIT_EMRS_EN
      ext_done_q <= ext_done_d;
`endif
      cke_q      <= cke_d;
      cs_n_q     <= cs_n_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pins.sdr_cke   = cke_q;
  assign pins.sdr_cs_n  = cs_n_q;
  assign pins.sdr_ras_n = cmd_q[2];
  assign pins.sdr_cas_n = cmd_q[1];
  assign pins.sdr_we_n  = cmd_q[0];
  assign pins.sdr_ba    = ba_q;
  assign pins.sdr_addr  = addr_q;
  assign init_busy      = busy_q;
  assign init_done      = done_q;

endmodule

// File: tb/tb_sdr_init_seq.sv
// tb/tb_sdr_init_seq.sv - scoreboard bench for sdr_init_seq over three parameter sets
module tb_sdr_init_seq;

  typedef struct packed {
    logic        done;
    logic        busy;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [31:0] off;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en0, en1, en2;
  logic [11:0] mode0 = 12'h033;
  logic [11:0] mode1 = 12'h5a5;
  logic [11:0] mode2 = 12'h127;
  logic [11:0] ext0  = 12'h040;
  logic [11:0] ext1  = 12'h040;
  logic [11:0] ext2  = 12'h040;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [2:0] done_v;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0[3];
  logic cke_p[3];
  logic done_p[3];
  evt_t exp_q[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign done_v = {done2, done1, done0};

  sdr_init_seq_if #(.SDR_AW(12)) pins0 ();
  sdr_init_seq_if #(.SDR_AW(12)) pins1 ();
  sdr_init_seq_if #(.SDR_AW(12)) pins2 ();

  sdr_init_seq #(.PWRUP_CYCLES(600), .TRP(3), .TRFC(7), .TMRD(2), .NUM_AREF(2), .SDR_AW(12)) dut0 (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_sdr_en(en0), .cfg_mode_reg(mode0),
`ifdef SDR_INIT_EMRS_EN
    .cfg_ext_mode_reg(ext0),
`endif
    .pins(pins0), .init_busy(busy0), .init_done(done0)
  );

  sdr_init_seq #(.PWRUP_CYCLES(4), .TRP(1), .TRFC(1), .TMRD(1), .NUM_AREF(1), .SDR_AW(12)) dut1 (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_sdr_en(en1), .cfg_mode_reg(mode1),
`ifdef SDR_INIT_EMRS_EN
    .cfg_ext_mode_reg(ext1),
`endif
    .pins(pins1), .init_busy(busy1), .init_done(done1)
  );

  sdr_init_seq #(.PWRUP_CYCLES(5), .TRP(3), .TRFC(7), .TMRD(2), .NUM_AREF(8), .SDR_AW(12)) dut2 (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_sdr_en(en2), .cfg_mode_reg(mode2),
`ifdef SDR_INIT_EMRS_EN
    .cfg_ext_mode_reg(ext2),
`endif
    .pins(pins2), .init_busy(busy2), .init_done(done2)
  );

  task automatic push_one(input int k, inout int n, input int lim, input evt_t e);
    if (n < lim) exp_q[k].push_back(e);
    n++;
  endtask

  // Expected commands with their offsets from the cycle in which cke rises.
  task automatic push_seq(input int k, input int pw, input int trp, input int trfc,
                          input int tmrd, input int na, input logic [11:0] mode,
                          input logic [11:0] ext, input int lim);
    int t = pw;
    int n = 0;
    push_one(k, n, lim, '{1'b0, 1'b1, 3'b010, 2'b00, 12'h400, t});
    t += trp;
    for (int i = 0; i < na; i++) begin
      push_one(k, n, lim, '{1'b0, 1'b1, 3'b001, 2'b00, 12'h000, t});
      t += trfc;
    end
    push_one(k, n, lim, '{1'b0, 1'b1, 3'b000, 2'b00, mode, t});
    t += tmrd;
`ifdef SDR_INIT_EMRS_EN
    push_one(k, n, lim, '{1'b0, 1'b1, 3'b000, 2'b01, ext, t});
    t += tmrd;
`else
    if (ext != mode) t += 0;
`endif
    push_one(k, n, lim, '{1'b1, 1'b0, 3'b111, 2'b00, 12'h000, t});
  endtask

  task automatic mon(input int k, input logic cke, input logic cs_n, input logic [2:0] cmd,
                     input logic [1:0] ba, input logic [11:0] addr, input logic busy,
                     input logic done);
    evt_t got, exp;
    if (cke === 1'b1 && cke_p[k] !== 1'b1) t0[k] = cyc;
    if (busy === 1'b1) begin
      total++;
      assert (cs_n === 1'b0 && cke === 1'b1)
      else begin
        bad++;
        $error("FAIL pins_active dut%0d cyc=%0d: cs_n=%b cke=%b, expected cs_n=0 cke=1", k, cyc, cs_n, cke);
      end
    end
    if ((cs_n === 1'b0 && cmd !== 3'b111) || (done === 1'b1 && done_p[k] !== 1'b1)) begin
      got = '{done, busy, cmd, ba, addr, cyc - t0[k]};
      exp = (exp_q[k].size() != 0) ? exp_q[k].pop_front() : '1;
      total++;
      assert (got === exp)
      else begin
        bad++;
        $error("FAIL evt dut%0d: got done=%b busy=%b cmd=%b ba=%b addr=%h off=%0d, expected done=%b busy=%b cmd=%b ba=%b addr=%h off=%0d",
               k, got.done, got.busy, got.cmd, got.ba, got.addr, got.off,
               exp.done, exp.busy, exp.cmd, exp.ba, exp.addr, exp.off);
      end
    end
    cke_p[k]  = cke;
    done_p[k] = done;
  endtask

  always @(negedge clk) mon(0, pins0.sdr_cke, pins0.sdr_cs_n,
      {pins0.sdr_ras_n, pins0.sdr_cas_n, pins0.sdr_we_n}, pins0.sdr_ba, pins0.sdr_addr, busy0, done0);
  always @(negedge clk) mon(1, pins1.sdr_cke, pins1.sdr_cs_n,
      {pins1.sdr_ras_n, pins1.sdr_cas_n, pins1.sdr_we_n}, pins1.sdr_ba, pins1.sdr_addr, busy1, done1);
  always @(negedge clk) mon(2, pins2.sdr_cke, pins2.sdr_cs_n,
      {pins2.sdr_ras_n, pins2.sdr_cas_n, pins2.sdr_we_n}, pins2.sdr_ba, pins2.sdr_addr, busy2, done2);

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (done_v[k] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (done_v[k] === 1'b1)
    else begin
      bad++;
      $error("FAIL done_timeout dut%0d: init_done=%b after %0d cycles, expected 1", k, done_v[k], n);
    end
  endtask

  task automatic check_q_empty(input int k, input string tag);
    total++;
    assert (exp_q[k].size() === 0)
    else begin
      bad++;
      $error("FAIL %s dut%0d: %0d expected commands not seen, expected 0", tag, k, exp_q[k].size());
    end
  endtask

  task automatic check_reset_pins(input string tag);
    logic [18:0] got;
    got = {pins0.sdr_cke, pins0.sdr_cs_n, pins0.sdr_ras_n, pins0.sdr_cas_n, pins0.sdr_we_n,
           pins0.sdr_ba, pins0.sdr_addr};
    total++;
    assert (got === {1'b0, 1'b1, 3'b111, 2'b00, 12'h000})
    else begin
      bad++;
      $error("FAIL %s pins: got %h, expected %h", tag, got, {1'b0, 1'b1, 3'b111, 2'b00, 12'h000});
    end
    total++;
    assert ({busy0, done0, busy1, done1, busy2, done2} === 6'b0)
    else begin
      bad++;
      $error("FAIL %s status: busy/done=%b, expected 000000", tag, {busy0, done0, busy1, done1, busy2, done2});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    en2 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Run 1: all three configurations, with stray enables during TRFC_W and DONE on dut0.
    push_seq(0, 600, 3, 7, 2, 2, mode0, ext0, 99);
    push_seq(1, 4, 1, 1, 1, 1, mode1, ext1, 99);
    push_seq(2, 5, 3, 7, 2, 8, mode2, ext2, 99);
    en0 = 1'b1;
    en1 = 1'b1;
    en2 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    en1 = 1'b0;
    en2 = 1'b0;
    total++;
    assert ({pins0.sdr_cke, busy0} === 2'b11)
    else begin
      bad++;
      $error("FAIL cke_rise: cke/busy=%b, expected 11", {pins0.sdr_cke, busy0});
    end
    repeat (605) @(negedge clk);
    en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    wait_done(0, 100);
    en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    assert ({done0, busy0, pins0.sdr_cke} === 3'b101)
    else begin
      bad++;
      $error("FAIL done_sticky: done/busy/cke=%b, expected 101", {done0, busy0, pins0.sdr_cke});
    end
    wait_done(1, 10);
    wait_done(2, 10);
    check_q_empty(0, "run1_left");
    check_q_empty(1, "run1_left");
    check_q_empty(2, "run1_left");

    // Run 2: reset during the second TRFC_W wait.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_seq(0, 600, 3, 7, 2, 2, mode0, ext0, 3);
    en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    repeat (612) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_pins("mid_reset");
    check_q_empty(0, "run2_left");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Run 3: full replay after the aborted sequence.
    push_seq(0, 600, 3, 7, 2, 2, mode0, ext0, 99);
    en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    wait_done(0, 700);
    repeat (3) @(negedge clk);
    check_q_empty(0, "run3_left");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
